mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one multiplier unit (mul/mac/dot/clpx datapath, multicycle MULH capable) between NREQ requesters, e.g. core EX stage and a DSP/accelerator port.
- Round-robin arbitration, request latching, multiplier sequencing, and one result buffer per transaction with valid/ready response backpressure.
- Sits between the requesters and the multiplier's enable/operator/operand/ex_ready/result/ready pins.

Parameters:
NREQ, 2, number of requesters (2..4)
OP_W, 3, width of multiplier operator code
IDW, $clog2(NREQ) (min 1), requester index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  abort in-flight/pending transaction
req_valid_i  in  NREQ  request valid per requester
req_ready_o  out  NREQ  request accepted (one-hot or zero)
req_op_i  in  NREQ*OP_W  operator per requester
req_signed_i  in  NREQ*2  short_signed per requester
req_a_i / req_b_i / req_c_i  in  NREQ*32 each  operands per requester
rsp_valid_o  out  1  result valid
rsp_id_o  out  IDW  owning requester index
rsp_result_o  out  32  result
rsp_ready_i  in  1  response consumed
mul_enable_o  out  1  multiplier enable
mul_operator_o  out  OP_W  latched operator
mul_short_signed_o  out  2  latched signedness
mul_op_a_o / mul_op_b_o / mul_op_c_o  out  32 each  latched operands
mul_ex_ready_o  out  1  downstream ready to multiplier
mul_result_i  in  32  multiplier result
mul_ready_i  in  1  multiplier result ready (low during multicycle)
busy_o  out  1  state != IDLE

Behaviour:
- Clock is clk; reset is asynchronous, active-low, on rst_n.
- Reset: state=IDLE, last_grant=NREQ-1, all outputs 0, operand/result/id registers 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If flush_i=0 and any req_valid_i: grant winner. req_ready_o[winner]=1 combinationally that cycle.
  - Latch op/signed/a/b/c/id; last_grant<=winner; ->BUSY.
  - If flush_i=1: no grant, req_ready_o=0.
- Arbitration: round-robin starting at last_grant+1 mod NREQ; first valid index wins. Exactly one grant per accept.
- BUSY:
  - mul_enable_o=1, mul_ex_ready_o=1, operand outputs from latches (stable for whole BUSY).
  - When mul_ready_i=1: capture mul_result_i; ->RESP. If drop flag is set, ->IDLE with no response.
  - mul_ready_i=0: stay (multicycle MULH).
- RESP:
  - rsp_valid_o=1, rsp_id_o/rsp_result_o held stable, mul_enable_o=0.
  - rsp_ready_i=1 -> IDLE. No new grant that same cycle.
- Latency: accept at cycle T. Single-cycle op with mul_ready_i=1 in first BUSY cycle gives rsp_valid_o at T+2. Each multicycle stall adds one cycle.
- Throughput: at most one transaction per 3 cycles. No overlap.
- flush_i:
  - In IDLE: blocks grant.
  - In BUSY: sets drop flag. Multiplier runs to mul_ready_i; result discarded; ->IDLE.
  - In RESP: rsp_valid_o drops next cycle; ->IDLE. Flush wins over a simultaneous rsp_ready_i; no double-count.
  - Drop flag clears on entering IDLE.
- Requester inputs are ignored outside IDLE. req_ready_o=0 in BUSY/RESP.
- Reset mid-operation: immediate return to IDLE; pending transaction lost; mul_enable_o=0.
- busy_o = (state!=IDLE).

Test Plan:
- Single request: req0 valid, op=MUL, a=7, b=6, mul_ready_i=1 immediately -> req_ready_o=01 at T, mul_enable_o=1 at T+1, rsp_valid_o=1, rsp_id_o=0, result=42 at T+2.
- Simultaneous requests, both valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1 for 4 transactions. First grant goes to 0 after reset.
- Multicycle: MULH, mul_ready_i low 4 cycles -> operands stable, mul_enable_o=1 for 5 cycles, rsp_valid_o at T+6.
- Backpressure: rsp_ready_i=0 for 3 cycles in RESP -> rsp_valid_o/result/id stable, req_ready_o=0, no new grant. Grant follows the cycle after the handshake.
- Flush in BUSY: flush_i pulse during MULH stall -> no rsp_valid_o, FSM to IDLE when mul_ready_i=1, next request served normally.
- Async reset: assert rst_n=0 mid-BUSY between clock edges -> mul_enable_o, busy_o, rsp_valid_o go 0 immediately; after release, last_grant=NREQ-1.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one multiplier datapath between NREQ requesters. A round-robin
//   arbiter grants one request at a time in IDLE, the winner's operands are
//   latched and held on the multiplier pins for the whole BUSY phase, and
//   the result is buffered in RESP until the consumer takes it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               abort in-flight/pending transaction
//   req_valid_i/ready_o   per-requester handshake (ready is one-hot or zero)
//   req_op/signed/a/b/c_i packed per-requester operator and operands
//   rsp_valid/id/result_o response buffer, held until rsp_ready_i
//   mul_*_o / mul_*_i     multiplier enable, operands, result and ready
//   busy_o                high whenever a transaction is owned
module mul_share_arbiter #(
  parameter int NREQ = 2,
  parameter int OP_W = 3,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*OP_W-1:0] req_op_i,
  input  logic [NREQ*2-1:0]    req_signed_i,
  input  logic [NREQ*32-1:0]   req_a_i,
  input  logic [NREQ*32-1:0]   req_b_i,
  input  logic [NREQ*32-1:0]   req_c_i,
  output logic                 rsp_valid_o,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [31:0]          rsp_result_o,
  input  logic                 rsp_ready_i,
  output logic                 mul_enable_o,
  output logic [OP_W-1:0]      mul_operator_o,
  output logic [1:0]           mul_short_signed_o,
  output logic [31:0]          mul_op_a_o,
  output logic [31:0]          mul_op_b_o,
  output logic [31:0]          mul_op_c_o,
  output logic                 mul_ex_ready_o,
  input  logic [31:0]          mul_result_i,
  input  logic                 mul_ready_i,
  output logic                 busy_o
);

  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic            drop_q, drop_d;
  logic [OP_W-1:0] op_q;
  logic [1:0]      sgn_q;
  logic [31:0]     a_q, b_q, c_q, result_q;
  logic [IDW-1:0]  id_q;

  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  grant_id;
  logic            grant_vld;
  logic            accept;
  logic            capture;

  // Round-robin search starting one past the last winner.
  always_comb begin
    cand      = '0;
    grant_id  = last_grant_q;
    grant_vld = 1'b0;
    for (int unsigned i = 1; i <= NREQ_U; i++) begin
      cand = IDW'((32'(last_grant_q) + i) % NREQ_U);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign accept  = (state_q == IDLE) && !flush_i && grant_vld;
  // A flush seen in the same cycle as mul_ready_i also discards the result.
  assign capture = (state_q == BUSY) && mul_ready_i && !(drop_q || flush_i);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (accept) begin
          state_d      = BUSY;
          last_grant_d = grant_id;
        end
      end
      BUSY: begin
        if (flush_i) drop_d = 1'b1;
        if (mul_ready_i) begin
          if (drop_q || flush_i) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (flush_i || rsp_ready_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ_U - 1);
      drop_q       <= 1'b0;
      op_q         <= '0;
      sgn_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      id_q         <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      if (accept) begin
        op_q <= req_op_i[grant_id*OP_W +: OP_W];
        sgn_q <= req_signed_i[grant_id*2 +: 2];
        a_q  <= req_a_i[grant_id*32 +: 32];
        b_q  <= req_b_i[grant_id*32 +: 32];
        c_q  <= req_c_i[grant_id*32 +: 32];
        id_q <= grant_id;
      end
      if (capture) result_q <= mul_result_i;
    end
  end

  assign req_ready_o        = accept ? (NREQ'(1) << grant_id) : '0;
  assign mul_enable_o       = (state_q == BUSY);
  assign mul_ex_ready_o     = (state_q == BUSY);
  assign mul_operator_o     = op_q;
  assign mul_short_signed_o = sgn_q;
  assign mul_op_a_o         = a_q;
  assign mul_op_b_o         = b_q;
  assign mul_op_c_o         = c_q;
  assign rsp_valid_o        = (state_q == RESP);
  assign rsp_id_o           = id_q;
  assign rsp_result_o       = result_q;
  assign busy_o             = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

  localparam int NREQ = 2;
  localparam int OP_W = 3;
  localparam int IDW  = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2:0]      op0, op1;
  logic [1:0]      sg0, sg1;
  logic [31:0]     a0, a1, b0, b1, c0, c1;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_ready;
  logic            mul_enable;
  logic [OP_W-1:0] mul_operator;
  logic [1:0]      mul_sgn;
  logic [31:0]     mul_a, mul_b, mul_c;
  logic            mul_ex_ready;
  logic [31:0]     mul_result;
  logic            mul_ready;
  logic            busy;

  int unsigned     checks = 0;
  int unsigned     failures = 0;
  int unsigned     stall_target = 0;
  int unsigned     en_cycles = 0;
  logic [39:0]     exp_q[$];
  logic [63:0]     prod;

  always #5 clk = ~clk;

  mul_share_arbiter #(.NREQ(NREQ), .OP_W(OP_W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i({op1, op0}), .req_signed_i({sg1, sg0}),
    .req_a_i({a1, a0}), .req_b_i({b1, b0}), .req_c_i({c1, c0}),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
    .rsp_ready_i(rsp_ready),
    .mul_enable_o(mul_enable), .mul_operator_o(mul_operator),
    .mul_short_signed_o(mul_sgn), .mul_op_a_o(mul_a), .mul_op_b_o(mul_b),
    .mul_op_c_o(mul_c), .mul_ex_ready_o(mul_ex_ready),
    .mul_result_i(mul_result), .mul_ready_i(mul_ready), .busy_o(busy)
  );

  // Multiplier model: op 0 = low product, op 1 = unsigned high product.
  assign prod       = {32'b0, mul_a} * {32'b0, mul_b};
  assign mul_result = (mul_operator == 3'd1) ? prod[63:32] : prod[31:0];
  assign mul_ready  = mul_enable && (en_cycles >= stall_target);

  always @(posedge clk) begin
    if (mul_enable) en_cycles <= en_cycles + 1;
    else            en_cycles <= 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every completed response handshake pops one entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {24'b0, 7'b0, rsp_id, rsp_result}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e[32]));
        chk("rsp_result", 64'(rsp_result), 64'(e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] grants [4];
    int         ng;

    rst_n = 1'b0; flush = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    op0 = '0; op1 = '0; sg0 = '0; sg1 = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; c0 = '0; c1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_enable", 64'(mul_enable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_op_a", 64'(mul_a), 64'd0);
    rst_n = 1'b1;

    // Single request, 7*6.
    tick();
    op0 = 3'd0; sg0 = 2'b01; a0 = 32'd7; b0 = 32'd6; c0 = 32'd3;
    req_valid = 2'b01; stall_target = 0;
    exp_q.push_back({7'b0, 1'b0, 32'd42});
    @(negedge clk);
    chk("t1_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_enable", 64'(mul_enable), 64'd1);
    chk("t1_ex_ready", 64'(mul_ex_ready), 64'd1);
    chk("t1_op_a", 64'(mul_a), 64'd7);
    chk("t1_op_b", 64'(mul_b), 64'd6);
    chk("t1_op_c", 64'(mul_c), 64'd3);
    chk("t1_sgn", 64'(mul_sgn), 64'h1);
    chk("t1_busy_no_ready", 64'(req_ready), 64'd0);
    chk("t1_rsp_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    wait_drain("t1_drain");

    // Both requesters continuously valid; last grant was 0.
    tick();
    op0 = 3'd0; op1 = 3'd0; a0 = 32'd3; b0 = 32'd5; a1 = 32'd10; b1 = 32'd11;
    req_valid = 2'b11;
    exp_q.push_back({7'b0, 1'b1, 32'd110});
    exp_q.push_back({7'b0, 1'b0, 32'd15});
    exp_q.push_back({7'b0, 1'b1, 32'd110});
    exp_q.push_back({7'b0, 1'b0, 32'd15});
    for (int g = 0; g < 4; g++) grants[g] = '0;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        grants[ng] = req_ready;
        ng++;
      end
    end
    tick();
    req_valid = '0;
    chk("t2_grant0", 64'(grants[0]), 64'h2);
    chk("t2_grant1", 64'(grants[1]), 64'h1);
    chk("t2_grant2", 64'(grants[2]), 64'h2);
    chk("t2_grant3", 64'(grants[3]), 64'h1);
    wait_drain("t2_drain");

    // Multicycle high multiply, 4 stall cycles.
    tick();
    op1 = 3'd1; a1 = 32'h8000_0000; b1 = 32'd4; stall_target = 4;
    req_valid = 2'b10;
    exp_q.push_back({7'b0, 1'b1, 32'd2});
    @(negedge clk);
    chk("t3_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0; a1 = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_enable", 64'(mul_enable), 64'd1);
      chk("t3_op_a_stable", 64'(mul_a), 64'h8000_0000);
      chk("t3_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    wait_drain("t3_drain");

    // Response backpressure with a competing request pending.
    tick();
    stall_target = 0; rsp_ready = 1'b0;
    op0 = 3'd0; a0 = 32'd9; b0 = 32'd9; op1 = 3'd0; a1 = 32'd10; b1 = 32'd11;
    req_valid = 2'b11;
    exp_q.push_back({7'b0, 1'b0, 32'd81});
    @(negedge clk);
    chk("t4_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b10;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_result", 64'(rsp_result), 64'd81);
      chk("t4_hold_id", 64'(rsp_id), 64'd0);
      chk("t4_no_grant", 64'(req_ready), 64'd0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_no_grant_hs", 64'(req_ready), 64'd0);
    tick();
    exp_q.push_back({7'b0, 1'b1, 32'd110});
    @(negedge clk);
    chk("t4_grant_after", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    wait_drain("t4_drain");

    // Flush during a multicycle stall: result discarded.
    tick();
    op0 = 3'd1; a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; stall_target = 4;
    req_valid = 2'b01;
    @(negedge clk);
    chk("t5_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_busy", 64'(busy), 64'd1);
      chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk);
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_no_rsp_end", 64'(rsp_valid), 64'd0);
    tick();
    op1 = 3'd0; a1 = 32'd2; b1 = 32'd3; stall_target = 0;
    req_valid = 2'b10;
    exp_q.push_back({7'b0, 1'b1, 32'd6});
    @(negedge clk);
    chk("t5_next_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    wait_drain("t5_drain");

    // Flush in RESP overrides a simultaneous rsp_ready.
    tick();
    op1 = 3'd0; a1 = 32'd4; b1 = 32'd4;
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    tick();
    chk("t7_in_resp", 64'(rsp_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t7_rsp_dropped", 64'(rsp_valid), 64'd0);
    chk("t7_idle", 64'(busy), 64'd0);

    // Asynchronous reset in BUSY.
    tick();
    op0 = 3'd0; a0 = 32'd5; b0 = 32'd5; stall_target = 4;
    req_valid = 2'b01;
    @(negedge clk);
    chk("t6_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_enable_low", 64'(mul_enable), 64'd0);
    chk("t6_busy_low", 64'(busy), 64'd0);
    chk("t6_rsp_low", 64'(rsp_valid), 64'd0);
    #4 rst_n = 1'b1;
    stall_target = 0;
    tick();
    req_valid = 2'b11;
    exp_q.push_back({7'b0, 1'b0, 32'd25});
    @(negedge clk);
    chk("t6_first_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    wait_drain("t6_drain");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
